// File: rtl/addsub_pipe_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package addsub_pipe_pkg;

   // Operation encoding carried alongside every beat.
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Number of chunk stages needed to cover in_width bits, stage_width bits at a time.
   function automatic int unsigned calc_num_stages(input int unsigned in_width,
                                                   input int unsigned stage_width);
      return (in_width + stage_width - 1) / stage_width;
   endfunction

endpackage

// File: rtl/addsub_stage.sv
// One chunk of the carry-pipelined adder: conditionally inverts B for subtract,
// adds the chunk with the incoming carry and registers sum, carry, op and valid.
module addsub_stage
   import addsub_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             valid_in,
   input  logic             op_in,
   input  logic             carry_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             valid_out,
   output logic             op_out,
   output logic             carry_out,
   output logic [WIDTH-1:0] sum
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   chunk;

   // Chunk adder; subtract is A + ~B with the borrow folded into carry_in upstream.
   always_comb begin
      b_eff = (op_in == OP_SUB) ? ~b : b;
      chunk = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
   end

   // Stage register; everything holds while the pipeline is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         op_out    <= 1'b0;
         carry_out <= 1'b0;
         sum       <= '0;
      end else if (en) begin
         valid_out <= valid_in;
         op_out    <= op_in;
         carry_out <= chunk[WIDTH];
         sum       <= chunk[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/addsub_pipe.sv
// Wide add/subtract pipelined on the carry chain. Chunk k is resolved in stage k
// using the registered carry of stage k-1. Operand chunks above chunk 0 are delayed
// (skewed) so they meet their carry, and result chunks below the top are delayed
// (deskewed) so all bits of a beat leave together. A single advance enable stalls
// every register at once when the output is blocked.
module addsub_pipe
   import addsub_pipe_pkg::*;
#(
   parameter int unsigned IN_WIDTH    = 501,
   parameter int unsigned STAGE_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                op,
   input  logic [IN_WIDTH-1:0] A,
   input  logic [IN_WIDTH-1:0] B,
   input  logic                Cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [IN_WIDTH-1:0] S,
   output logic                Cout,
   output logic                Ovf
);

   localparam int unsigned NUM_STAGES = calc_num_stages(IN_WIDTH, STAGE_WIDTH);
   localparam int unsigned LAST_WIDTH = IN_WIDTH - (NUM_STAGES - 1) * STAGE_WIDTH;

   logic adv;

   // Per-stage chains; index k feeds stage k, index k+1 is driven by stage k.
   wire [NUM_STAGES:0] valid_chain;
   wire [NUM_STAGES:0] op_chain;
   wire [NUM_STAGES:0] carry_chain;
   wire [IN_WIDTH-1:0] sum_all;

   // Effective sign bits of the top chunk, registered in step with the last stage.
   logic sign_a_d;
   logic sign_b_d;
   logic sign_a_q;
   logic sign_b_q;

   // The op copy leaving the last stage has no consumer.
   logic unused_op;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   assign valid_chain[0] = in_valid;
   assign op_chain[0]    = op;
   // Subtract uses A + ~B + (1 - Cin), so the borrow-in enters inverted.
   assign carry_chain[0] = (op == OP_SUB) ? ~Cin : Cin;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      localparam int unsigned W      = (k == NUM_STAGES - 1) ? LAST_WIDTH : STAGE_WIDTH;
      localparam int unsigned LO     = k * STAGE_WIDTH;
      localparam int unsigned DESKEW = NUM_STAGES - 1 - k;

      logic [W-1:0] a_cur;
      logic [W-1:0] b_cur;
      logic [W-1:0] s_stage;

      if (k == 0) begin : g_noskew
         assign a_cur = A[LO +: W];
         assign b_cur = B[LO +: W];
      end else begin : g_skew
         // k-deep delay line per operand; oldest slot sits at the top.
         logic [(k+1)*W-1:0] a_sh;
         logic [(k+1)*W-1:0] b_sh;
         logic [k*W-1:0]     a_sr;
         logic [k*W-1:0]     b_sr;

         assign a_sh  = {a_sr, A[LO +: W]};
         assign b_sh  = {b_sr, B[LO +: W]};
         assign a_cur = a_sh[(k+1)*W-1 -: W];
         assign b_cur = b_sh[(k+1)*W-1 -: W];

         // Operand skew: chunk k waits k cycles for its carry.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_sr <= '0;
               b_sr <= '0;
            end else if (adv) begin
               a_sr <= a_sh[k*W-1:0];
               b_sr <= b_sh[k*W-1:0];
            end
         end
      end

      addsub_stage #(
         .WIDTH (W)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .en        (adv),
         .valid_in  (valid_chain[k]),
         .op_in     (op_chain[k]),
         .carry_in  (carry_chain[k]),
         .a         (a_cur),
         .b         (b_cur),
         .valid_out (valid_chain[k+1]),
         .op_out    (op_chain[k+1]),
         .carry_out (carry_chain[k+1]),
         .sum       (s_stage)
      );

      if (DESKEW == 0) begin : g_nodeskew
         assign sum_all[LO +: W] = s_stage;
      end else begin : g_deskew
         logic [(DESKEW+1)*W-1:0] s_sh;
         logic [DESKEW*W-1:0]     s_sr;

         assign s_sh             = {s_sr, s_stage};
         assign sum_all[LO +: W] = s_sh[(DESKEW+1)*W-1 -: W];

         // Result deskew: lower chunks wait for the top chunk to finish.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s_sr <= '0;
            end else if (adv) begin
               s_sr <= s_sh[DESKEW*W-1:0];
            end
         end
      end

      if (k == NUM_STAGES - 1) begin : g_sign
         assign sign_a_d = a_cur[W-1];
         assign sign_b_d = b_cur[W-1] ^ (op_chain[k] == OP_SUB);
      end
   end

   // Capture operand signs together with the top chunk so Ovf lines up with S.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
      end else if (adv) begin
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
      end
   end

   assign S         = sum_all;
   assign Cout      = carry_chain[NUM_STAGES];
   assign out_valid = valid_chain[NUM_STAGES];
   assign Ovf       = (sign_a_q == sign_b_q) && (S[IN_WIDTH-1] != sign_a_q);
   assign unused_op = op_chain[NUM_STAGES];

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe at 501 bits / 32-bit stages (16 stages).
module tb_addsub_pipe;

   localparam int unsigned W = 501;
   localparam int LAT = 16;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         op;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] S;
   logic         Cout;
   logic         Ovf;

   int total;
   int bad;

   addsub_pipe #(
      .IN_WIDTH    (W),
      .STAGE_WIDTH (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Cout      (Cout),
      .Ovf       (Ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result packed as {ovf, cout, s}.
   function automatic logic [W+1:0] model(input logic o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic c);
      logic [W:0] r;
      logic       bs;
      logic       v;
      if (o) begin
         r  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~c};
         bs = ~b[W-1];
      end else begin
         r  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
         bs = b[W-1];
      end
      v = (a[W-1] == bs) && (r[W-1] != a[W-1]);
      return {v, r};
   endfunction

   function automatic logic [W-1:0] rand_vec();
      logic [511:0] t;
      for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
      return t[W-1:0];
   endfunction

   task automatic drive(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
      in_valid = 1'b1;
      op       = o;
      A        = a;
      B        = b;
      Cin      = c;
   endtask

   // Issue one beat into an idle pipe and wait (bounded) for its result.
   task automatic send_one(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, output logic [W+1:0] got, output int lat);
      drive(o, a, b, c);
      @(posedge clk);
      #1 in_valid = 1'b0;
      got = '0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            got = {Ovf, Cout, S};
            lat = i;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      total++; if (S !== {W{1'b0}}) begin bad++; $display("FAIL reset_s: got %h want 0", S); end
      total++; if (Cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %0b want 0", Cout); end
      total++; if (Ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b want 0", Ovf); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid: got %0b want 0", out_valid); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_add_carry();
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W+1:0] got;
      logic [W+1:0] exp;
      int           lat;
      // all-ones + 0 + 1 wraps to zero with carry out
      a = '1;
      b = '0;
      send_one(1'b0, a, b, 1'b1, got, lat);
      exp = {1'b0, 1'b1, {W{1'b0}}};
      total++; if (got !== exp) begin bad++; $display("FAIL add_allones: got %h want %h", got, exp); end
      total++; if (lat !== LAT) begin bad++; $display("FAIL add_latency: got %0d want %0d", lat, LAT); end
      // carry crossing the chunk 0 / chunk 1 boundary
      a = '0;
      a[31:0] = '1;
      b = W'(1);
      send_one(1'b0, a, b, 1'b0, got, lat);
      exp = '0;
      exp[32] = 1'b1;
      total++; if (got !== exp) begin bad++; $display("FAIL add_chunk_carry: got %h want %h", got, exp); end
   endtask

   task automatic test_sub();
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W+1:0] got;
      logic [W+1:0] exp;
      int           lat;
      // 5 - 7 - 0 = 2^501 - 2, borrow
      a = W'(5);
      b = W'(7);
      send_one(1'b1, a, b, 1'b0, got, lat);
      exp = '0;
      exp[W-1:0] = '1;
      exp[0] = 1'b0;
      total++; if (got !== exp) begin bad++; $display("FAIL sub_5_7: got %h want %h", got, exp); end
      total++; if (lat !== LAT) begin bad++; $display("FAIL sub_latency: got %0d want %0d", lat, LAT); end
      // 7 - 5 - 1 = 1, no borrow
      a = W'(7);
      b = W'(5);
      send_one(1'b1, a, b, 1'b1, got, lat);
      exp = '0;
      exp[W] = 1'b1;
      exp[0] = 1'b1;
      total++; if (got !== exp) begin bad++; $display("FAIL sub_7_5_1: got %h want %h", got, exp); end
      // 0 - 0 - 1 = all ones, borrow
      a = '0;
      b = '0;
      send_one(1'b1, a, b, 1'b1, got, lat);
      exp = '0;
      exp[W-1:0] = '1;
      total++; if (got !== exp) begin bad++; $display("FAIL sub_0_0_1: got %h want %h", got, exp); end
   endtask

   task automatic test_ovf();
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W+1:0] got;
      logic [W+1:0] exp;
      int           lat;
      // max positive + 1 -> min negative
      a = '1;
      a[W-1] = 1'b0;
      b = W'(1);
      send_one(1'b0, a, b, 1'b0, got, lat);
      exp = '0;
      exp[W-1] = 1'b1;
      exp[W+1] = 1'b1;
      total++; if (got !== exp) begin bad++; $display("FAIL add_ovf: got %h want %h", got, exp); end
      // min negative - 1 -> max positive, no borrow
      a = '0;
      a[W-1] = 1'b1;
      b = W'(1);
      send_one(1'b1, a, b, 1'b0, got, lat);
      exp = '0;
      exp[W-2:0] = '1;
      exp[W] = 1'b1;
      exp[W+1] = 1'b1;
      total++; if (got !== exp) begin bad++; $display("FAIL sub_ovf: got %h want %h", got, exp); end
   endtask

   task automatic test_bubbles();
      logic [W+1:0] exp0;
      logic [W+1:0] exp1;
      int           stray;
      exp0 = {2'b00, W'(3)};
      exp1 = {2'b01, W'(7)};
      stray = 0;
      drive(1'b0, W'(1), W'(2), 1'b0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 drive(1'b1, W'(10), W'(3), 1'b0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 3; i <= 22; i++) begin
         @(negedge clk);
         if (i == 16) begin
            total++; if ({out_valid, Ovf, Cout, S} !== {1'b1, exp0}) begin bad++; $display("FAIL bubble_beat0: got %0b %h want 1 %h", out_valid, {Ovf, Cout, S}, exp0); end
         end else if (i == 17) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bubble_slot: got %0b want 0", out_valid); end
         end else if (i == 18) begin
            total++; if ({out_valid, Ovf, Cout, S} !== {1'b1, exp1}) begin bad++; $display("FAIL bubble_beat1: got %0b %h want 1 %h", out_valid, {Ovf, Cout, S}, exp1); end
         end else if (out_valid) begin
            stray++;
         end
      end
      total++; if (stray !== 0) begin bad++; $display("FAIL bubble_stray: got %0d want 0", stray); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] va [60];
      logic [W-1:0] vb [60];
      logic         vo [60];
      logic         vc [60];
      logic [W+1:0] ex [60];
      int           got_n;
      int           first;
      int           last;
      int           gaps;
      for (int i = 0; i < 60; i++) begin
         va[i] = rand_vec();
         vb[i] = rand_vec();
         vo[i] = (i % 2 == 1);
         vc[i] = 1'($urandom_range(0, 1));
         ex[i] = model(vo[i], va[i], vb[i], vc[i]);
      end
      got_n = 0;
      first = -1;
      last  = -1;
      gaps  = 0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               drive(vo[i], va[i], vb[i], vc[i]);
               @(posedge clk);
               #1;
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 150 && got_n < 60; c++) begin
               @(negedge clk);
               if (out_valid) begin
                  total++;
                  if ({Ovf, Cout, S} !== ex[got_n]) begin
                     bad++;
                     $display("FAIL b2b_beat%0d: got %h want %h", got_n, {Ovf, Cout, S}, ex[got_n]);
                  end
                  if (first < 0) first = c;
                  else if (c != last + 1) gaps++;
                  last = c;
                  got_n++;
               end
            end
         end
      join
      total++; if (got_n !== 60) begin bad++; $display("FAIL b2b_count: got %0d want 60", got_n); end
      total++; if (first !== LAT) begin bad++; $display("FAIL b2b_first_latency: got %0d want %0d", first, LAT); end
      total++; if (gaps !== 0) begin bad++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_stall();
      logic [W-1:0] va [25];
      logic [W-1:0] vb [25];
      logic         vo [25];
      logic         vc [25];
      logic [W+1:0] ex [25];
      int           got_n;
      int           stall_n;
      for (int i = 0; i < 25; i++) begin
         va[i] = rand_vec();
         vb[i] = rand_vec();
         vo[i] = 1'($urandom_range(0, 1));
         vc[i] = 1'($urandom_range(0, 1));
         ex[i] = model(vo[i], va[i], vb[i], vc[i]);
      end
      got_n   = 0;
      stall_n = 0;
      fork
         begin : drv
            int   i;
            logic rdy;
            i = 0;
            while (i < 25) begin
               drive(vo[i], va[i], vb[i], vc[i]);
               @(negedge clk);
               rdy = in_ready;
               @(posedge clk);
               #1;
               if (rdy) i++;
            end
            in_valid = 1'b0;
         end
         begin
            repeat (20) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            for (int c = 0; c < 200 && got_n < 25; c++) begin
               @(negedge clk);
               if (!out_ready) begin
                  stall_n++;
                  total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %0b want 0", in_ready); end
                  total++;
                  if ({out_valid, Ovf, Cout, S} !== {1'b1, ex[got_n]}) begin
                     bad++;
                     $display("FAIL stall_hold: got %0b %h want 1 %h", out_valid, {Ovf, Cout, S}, ex[got_n]);
                  end
               end else if (out_valid) begin
                  total++;
                  if ({Ovf, Cout, S} !== ex[got_n]) begin
                     bad++;
                     $display("FAIL stall_beat%0d: got %h want %h", got_n, {Ovf, Cout, S}, ex[got_n]);
                  end
                  got_n++;
               end
            end
         end
      join
      total++; if (stall_n !== 5) begin bad++; $display("FAIL stall_cycles: got %0d want 5", stall_n); end
      total++; if (got_n !== 25) begin bad++; $display("FAIL stall_count: got %0d want 25", got_n); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midstream();
      logic [W+1:0] got;
      logic [W+1:0] exp;
      int           lat;
      int           stray;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, rand_vec(), rand_vec(), 1'b0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid: got %0b want 1", out_valid); end
      rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
      total++; if ({Ovf, Cout, S} !== {(W+2){1'b0}}) begin bad++; $display("FAIL midrst_outputs: got %h want 0", {Ovf, Cout, S}); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
      @(posedge clk);
      #1 rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) stray++;
      end
      total++; if (stray !== 0) begin bad++; $display("FAIL midrst_stale: got %0d want 0", stray); end
      @(posedge clk);
      #1;
      send_one(1'b0, W'(3), W'(4), 1'b1, got, lat);
      exp = {2'b00, W'(8)};
      total++; if (got !== exp) begin bad++; $display("FAIL midrst_beat: got %h want %h", got, exp); end
      total++; if (lat !== LAT) begin bad++; $display("FAIL midrst_latency: got %0d want %0d", lat, LAT); end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 1'b0;
      A         = '0;
      B         = '0;
      Cin       = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_add_carry();
      test_sub();
      test_ovf();
      test_bubbles();
      test_back_to_back();
      test_stall();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
